regfile_2r1w: RTL and testbench



---
 rtl/regfile_2r1w.sv | 123 ++++++++++++
 tb/tb_regfile_2r1w.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with byte-enabled writes, write-first forwarding,
// an optional hardwired zero entry and a clear sequencer that sweeps the array to zero.
module regfile_2r1w #(
  parameter int unsigned B        = 16,
  parameter int unsigned W        = 4,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [W-1:0]   w_addr,
  input  logic [B/8-1:0] w_be,
  input  logic [B-1:0]   w_data,
  input  logic [W-1:0]   ra_addr,
  input  logic [W-1:0]   rb_addr,
  input  logic           clr_req,
  output logic [B-1:0]   ra_data,
  output logic [B-1:0]   rb_data,
  output logic           busy,
  output logic           wr_err
);

  localparam int unsigned NB    = B / 8;
  localparam int unsigned Depth = 2 ** W;

  typedef enum logic {StClear, StIdle} state_e;

  state_e       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [B-1:0] mem [Depth];

  logic [B-1:0] ra_data_q, ra_data_d;
  logic [B-1:0] rb_data_q, rb_data_d;
  logic         busy_q, busy_d;
  logic         wr_err_q, wr_err_d;

  logic         clearing;
  logic         w_zero;
  logic         wr_do;
  logic [B-1:0] merged;

  assign clearing = (state_q == StClear);
  assign w_zero   = ZERO_REG && (w_addr == '0);
  // A pending clear request takes priority over a write issued in the same cycle.
  assign wr_do    = wr_en && !clearing && !clr_req && !w_zero;

  always_comb begin
    merged = mem[w_addr];
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_be[i]) merged[8*i +: 8] = w_data[8*i +: 8];
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StClear;
      ptr_q     <= '0;
      ra_data_q <= '0;
      rb_data_q <= '0;
      busy_q    <= 1'b1;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
      busy_q    <= busy_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StClear: begin
        ptr_d = ptr_q + W'(1);
        if (&ptr_q) begin
          state_d = StIdle;
          ptr_d   = '0;
        end
      end
      StIdle: begin
        if (clr_req) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = StClear;
        ptr_d   = '0;
      end
    endcase
  end

  // Output next values
  always_comb begin
    busy_d   = (state_d == StClear);
    wr_err_d = wr_en && (clearing || clr_req);

    if (clearing || (ZERO_REG && (ra_addr == '0))) ra_data_d = '0;
    else if (wr_do && (ra_addr == w_addr))         ra_data_d = merged;
    else                                           ra_data_d = mem[ra_addr];

    if (clearing || (ZERO_REG && (rb_addr == '0))) rb_data_d = '0;
    else if (wr_do && (rb_addr == w_addr))         rb_data_d = merged;
    else                                           rb_data_d = mem[rb_addr];
  end

  // Storage carries no reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (clearing)   mem[ptr_q]  <= '0;
    else if (wr_do) mem[w_addr] <= merged;
  end

  assign ra_data = ra_data_q;
  assign rb_data = rb_data_q;
  assign busy    = busy_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: two instances (ZERO_REG off and on) share one stimulus stream
// and are checked each cycle against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [1:0]  w_addr;
  logic [1:0]  w_be;
  logic [15:0] w_data;
  logic [1:0]  ra_addr;
  logic [1:0]  rb_addr;
  logic        clr_req;

  logic [15:0] ra0, rb0, ra1, rb1;
  logic        busy0, busy1, err0, err1;

  int n_total = 0;
  int n_pass  = 0;
  string ctx = "";

  // Reference model state
  logic [15:0] mm [2][4];
  int          clr_left;
  logic [15:0] e_ra [2];
  logic [15:0] e_rb [2];
  logic        e_busy;
  logic        e_err;

  always #5 clk = ~clk;

  regfile_2r1w #(.B(16), .W(2), .ZERO_REG(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .clr_req(clr_req),
    .ra_data(ra0), .rb_data(rb0), .busy(busy0), .wr_err(err0)
  );

  regfile_2r1w #(.B(16), .W(2), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .clr_req(clr_req),
    .ra_data(ra1), .rb_data(rb1), .busy(busy1), .wr_err(err1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed %h expected %h", ctx, tag, obs, exp);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [1:0] be,
                                        input logic [15:0] nw);
    logic [15:0] r;
    r[7:0]  = be[0] ? nw[7:0]  : old[7:0];
    r[15:8] = be[1] ? nw[15:8] : old[15:8];
    return r;
  endfunction

  function automatic logic [15:0] model_read(input int k, input logic [1:0] a, input bit clearing,
                                             input bit wp);
    if (clearing || (k == 1 && a == 2'd0)) return 16'h0000;
    if (wp && a == w_addr) return merge(mm[k][a], w_be, w_data);
    return mm[k][a];
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit clearing;
    bit wp;
    clearing = (clr_left > 0);
    for (int k = 0; k < 2; k++) begin
      wp = wr_en && !clearing && !clr_req && !(k == 1 && w_addr == 2'd0);
      e_ra[k] = model_read(k, ra_addr, clearing, wp);
      e_rb[k] = model_read(k, rb_addr, clearing, wp);
      if (wp) mm[k][w_addr] = merge(mm[k][w_addr], w_be, w_data);
      if (clearing) mm[k][4 - clr_left] = 16'h0000;
    end
    e_err = wr_en && (clearing || clr_req);
    if (clearing) clr_left--;
    else if (clr_req) clr_left = 4;
    e_busy = (clr_left > 0);
  endtask

  task automatic check_all();
    chk("ra0", ra0, e_ra[0]);
    chk("rb0", rb0, e_rb[0]);
    chk("ra1", ra1, e_ra[1]);
    chk("rb1", rb1, e_rb[1]);
    chk("busy0", 16'(busy0), 16'(e_busy));
    chk("busy1", 16'(busy1), 16'(e_busy));
    chk("err0", 16'(err0), 16'(e_err));
    chk("err1", 16'(err1), 16'(e_err));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [1:0] be,
                       input logic [15:0] wd, input logic [1:0] ra, input logic [1:0] rb,
                       input logic cr);
    wr_en = we; w_addr = wa; w_be = be; w_data = wd;
    ra_addr = ra; rb_addr = rb; clr_req = cr;
  endtask

  task automatic idle();
    drive(1'b0, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clr_left = 4;
    for (int k = 0; k < 2; k++) begin
      e_ra[k] = 16'h0000;
      e_rb[k] = 16'h0000;
    end
    e_busy = 1'b1;
    e_err  = 1'b0;
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep_and_read();
    idle();
    for (int i = 0; i < 4; i++) step();
    chk("busy_after_sweep", 16'(busy0), 16'h0000);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'd0, 2'b00, 16'h0000, 2'(i), 2'(3 - i), 1'b0);
      step();
      chk("swept_ra", ra0, 16'h0000);
      chk("swept_rb", rb0, 16'h0000);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 4; a++) mm[k][a] = 16'h0000;

    ctx = "reset";
    apply_reset();
    sweep_and_read();

    ctx = "byte_en";
    drive(1'b1, 2'd2, 2'b11, 16'hABCD, 2'd0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd2, 2'b01, 16'h1234, 2'd0, 2'd0, 1'b0); step();
    drive(1'b0, 2'd0, 2'b00, 16'h0000, 2'd2, 2'd2, 1'b0); step();
    chk("ra_ab34", ra0, 16'hAB34);
    chk("rb_ab34", rb0, 16'hAB34);

    ctx = "forward";
    drive(1'b1, 2'd1, 2'b11, 16'h5555, 2'd0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd1, 2'b10, 16'hAA00, 2'd1, 2'd1, 1'b0); step();
    chk("fwd_ra", ra0, 16'hAA55);
    chk("fwd_rb", rb0, 16'hAA55);

    ctx = "clr_vs_write";
    drive(1'b1, 2'd3, 2'b11, 16'hFFFF, 2'd0, 2'd0, 1'b0); step();
    drive(1'b1, 2'd3, 2'b11, 16'h0F0F, 2'd3, 2'd3, 1'b1); step();
    chk("drop_err", 16'(err0), 16'h0001);
    chk("drop_busy", 16'(busy0), 16'h0001);
    drive(1'b1, 2'd3, 2'b11, 16'h0F0F, 2'd3, 2'd3, 1'b0); step();
    chk("busy_write_err", 16'(err0), 16'h0001);
    idle();
    for (int i = 0; i < 3; i++) step();
    chk("clr_done_busy", 16'(busy0), 16'h0000);
    drive(1'b0, 2'd0, 2'b00, 16'h0000, 2'd3, 2'd2, 1'b0); step();
    chk("addr3_cleared", ra0, 16'h0000);

    ctx = "zero_reg";
    drive(1'b1, 2'd0, 2'b11, 16'h7777, 2'd0, 2'd0, 1'b0); step();
    chk("zr_err", 16'(err1), 16'h0000);
    chk("zr_fwd", ra1, 16'h0000);
    chk("nozr_fwd", ra0, 16'h7777);
    drive(1'b0, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd0, 1'b0); step();
    chk("zr_read", ra1, 16'h0000);

    ctx = "reset_mid_clear";
    drive(1'b0, 2'd0, 2'b00, 16'h0000, 2'd0, 2'd0, 1'b1); step();
    idle();
    step();
    step();
    apply_reset();
    sweep_and_read();

    ctx = "random";
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 2'($urandom),
            2'($urandom), 1'($urandom_range(0, 15) == 0));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
